// File: rtl/cmul_pkg.sv
// ============================================================
// cmul_pkg : shared types and constants for constant multipliers
// Rev 1.0
// ============================================================
`default_nettype none

package cmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CMUL_K  = 83;
  localparam int CMUL_KW = 7;

  function automatic int cmul_pw(input int w, input int kw);
    return w + kw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmul_seq_if.sv
// ============================================================
// cmul_seq_if : valid/ready operand and result channels
// Rev 1.0
// ============================================================
`default_nettype none

interface cmul_seq_if #(
  parameter int W  = 8,
  parameter int OW = 8
);
  logic          sat_mode;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_ovf;

  modport master (
    output sat_mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  sat_mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/cmul_narrow.sv
// ============================================================
// cmul_narrow : full product -> truncated/saturated result + overflow
// Rev 1.0
// ============================================================
`default_nettype none

module cmul_narrow #(
  parameter int PW = 15,
  parameter int OW = 8
) (
  input  wire logic [PW-1:0] i_p,
  input  wire logic          i_sat,
  output logic      [OW-1:0] o_data,
  output logic               o_ovf
);

  logic w_ovf;

  generate
    if (OW < PW) begin : g_ovf
      assign w_ovf = |i_p[PW-1:OW];
    end else begin : g_no_ovf
      assign w_ovf = 1'b0;
    end
  endgenerate

  assign o_ovf  = w_ovf;
  assign o_data = (i_sat && w_ovf) ? {OW{1'b1}} : i_p[OW-1:0];

endmodule

`default_nettype wire

// File: rtl/cmul_seq.sv
// ============================================================
// cmul_seq : sequential shift-add multiplier by constant K, one K bit per clock
// Rev 1.0
// ============================================================
`default_nettype none

module cmul_seq
  import cmul_pkg::*;
#(
  parameter int          W  = 8,
  parameter int          KW = CMUL_KW,
  parameter int unsigned K  = CMUL_K,
  parameter int          OW = 8
) (
  input wire logic  clk,
  input wire logic  rst_n,
  cmul_seq_if.slave bus
);

  localparam int PW = cmul_pw(W, KW);
  // One extra bit so the counter cannot wrap before the terminal compare
  localparam int CW = $clog2(KW) + 1;
  localparam logic [KW-1:0] c_k    = KW'(K);
  localparam logic [CW-1:0] c_last = CW'(KW - 1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_acc, w_acc_nxt, w_addend;
  logic [W-1:0]  r_op;
  logic [CW-1:0] r_cnt;
  logic          r_sat;
  logic [OW-1:0] r_out_data, w_n_data;
  logic          r_out_ovf, w_n_ovf;
  logic [KW-1:0] w_kshift;
  logic          w_accept, w_last;

  assign bus.in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_last       = (r_cnt == c_last);

  assign w_kshift  = c_k >> r_cnt;
  assign w_addend  = {{KW{1'b0}}, r_op} << r_cnt;
  assign w_acc_nxt = w_kshift[0] ? (r_acc + w_addend) : r_acc;

  cmul_narrow #(
    .PW (PW),
    .OW (OW)
  ) u_narrow (
    .i_p    (w_acc_nxt),
    .i_sat  (r_sat),
    .o_data (w_n_data),
    .o_ovf  (w_n_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = bus.in_valid ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_op       <= '0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_op  <= bus.in_data;
      r_sat <= bus.sat_mode;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      // Result is captured on the final add so it stays frozen through backpressure
      if (w_last) begin
        r_out_data <= w_n_data;
        r_out_ovf  <= w_n_ovf;
      end
    end
  end

  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;

endmodule

`default_nettype wire
